// File: rtl/conv_pkg.sv
// Shared constants and elaboration-time helpers for the streaming convolution layer.
package conv_pkg;

  localparam int unsigned ACT_IDENTITY = 0;
  localparam int unsigned ACT_RELU     = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned out_dim(input int unsigned w, input int unsigned k,
                                          input int unsigned s);
    return (w - k) / s + 1;
  endfunction

  // Wide enough that the full sum of products plus bias cannot overflow.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ch,
                                            input int unsigned k);
    return 2 * dw + clog2(ch * k * k) + 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One channel's K-1 row buffers plus the KxK window; window tap (r,q) is image
// pixel (row-K+1+r, col-K+1+q) relative to the most recently shifted-in pixel.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned W  = 28,
  parameter int unsigned K  = 3
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [clog2(W)-1:0]   col,
  input  logic [DW-1:0]         din,
  output logic [K*K*DW-1:0]     window
);

  logic [DW-1:0] lines [K-1][W];
  logic [DW-1:0] win   [K][K];

  // lines[K-2] holds the previous row, lines[0] the oldest; each accepted pixel
  // pushes its column one row older and slides the window left by one.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned r = 0; r + 2 < K; r++) begin
        lines[r][col] <= lines[r+1][col];
      end
      lines[K-2][col] <= din;
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned q = 0; q + 1 < K; q++) begin
          win[r][q] <= win[r][q+1];
        end
      end
      for (int unsigned r = 0; r + 1 < K; r++) begin
        win[r][K-1] <= lines[r][col];
      end
      win[K-1][K-1] <= din;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar q = 0; q < K; q++) begin : g_col
      assign window[(r*K+q)*DW +: DW] = win[r][q];
    end
  end

endmodule

// File: rtl/conv_layer_mc.sv
// Streaming multi-channel KxK convolution with bias and activation, 3-cycle pipeline.
// Define CONV_SAT_EN to saturate the final narrowing instead of wrapping.
module conv_layer_mc
  import conv_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned W      = 28,
  parameter int unsigned K      = 3,
  parameter int unsigned S      = 1,
  parameter int unsigned CH     = 1,
  parameter int unsigned ACTYPE = 1
) (
  input  logic                   clk,
  input  logic                   global_rst,
  input  logic                   in_valid,
  input  logic [CH*DW-1:0]       in_data,
  input  logic [CH*K*K*DW-1:0]   weight,
  input  logic [DW-1:0]          bias,
  output logic [DW-1:0]          data_out,
  output logic                   valid_op,
  output logic                   end_op,
  output logic                   busy
);

  localparam int unsigned CW   = clog2(W);
  localparam int unsigned NT   = CH * K * K;
  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned ACCW = acc_width(DW, CH, K);
  localparam int unsigned LAST = (K - 1) + (out_dim(W, K, S) - 1) * S;

  logic [CW-1:0]          row, col;
  logic                   accept_c, first_c, final_c, win_ok_c, last_c;
  logic                   frame_open;
  logic [NT*DW-1:0]       win_flat, w_lat;
  logic [DW-1:0]          b_lat;
  logic                   v0, l0, v1, l1, v2, l2;
  logic signed [PW-1:0]   prod [NT];
  logic signed [ACCW-1:0] acc_c, sum, res_c;
  logic [DW-1:0]          out_c;

  assign accept_c = in_valid && !global_rst;
  assign first_c  = (row == '0) && (col == '0);
  assign final_c  = (row == CW'(W - 1)) && (col == CW'(W - 1));
  assign last_c   = (row == CW'(LAST)) && (col == CW'(LAST));
  assign win_ok_c = (32'(row) >= K - 1) && (32'(col) >= K - 1) &&
                    (((32'(row) - (K - 1)) % S) == 0) &&
                    (((32'(col) - (K - 1)) % S) == 0);

  // Raster position of the next pixel, plus frame bookkeeping for busy.
  always_ff @(posedge clk) begin
    if (global_rst) begin
      row        <= '0;
      col        <= '0;
      frame_open <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (accept_c) begin
        if (col == CW'(W - 1)) begin
          col <= '0;
          row <= (row == CW'(W - 1)) ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (first_c) frame_open <= 1'b1;
        else if (final_c) frame_open <= 1'b0;
      end
      if (accept_c && first_c) busy <= 1'b1;
      else if (end_op) busy <= frame_open;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c && first_c) begin
      w_lat <= weight;
      b_lat <= bias;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    conv_line_buffer #(.DW(DW), .W(W), .K(K)) u_lb (
      .clk    (clk),
      .en     (accept_c),
      .col    (col),
      .din    (in_data[c*DW +: DW]),
      .window (win_flat[c*K*K*DW +: K*K*DW])
    );
  end

  always_comb begin
    acc_c = ACCW'($signed(b_lat)) <<< FRAC;
    for (int unsigned i = 0; i < NT; i++) begin
      acc_c = acc_c + ACCW'(prod[i]);
    end
  end

  always_comb begin
    res_c = sum >>> FRAC;
    case (ACTYPE)
      ACT_IDENTITY: ;
      ACT_RELU:     if (res_c[ACCW-1]) res_c = '0;
      default:      ;
    endcase
  end

`ifdef CONV_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'd1 << (DW - 1)) - 64'd1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    out_c = DW'(res_c);
    if (res_c > SAT_MAX) out_c = DW'(SAT_MAX);
    else if (res_c < SAT_MIN) out_c = DW'(SAT_MIN);
  end
`else
  always_comb begin
    out_c = DW'(res_c);
  end
`endif

  // Data path registers: products, sum, narrowed result; stages never stall.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NT; i++) begin
      prod[i] <= PW'($signed(win_flat[i*DW +: DW])) * PW'($signed(w_lat[i*DW +: DW]));
    end
    sum <= acc_c;
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      v0       <= 1'b0;
      l0       <= 1'b0;
      v1       <= 1'b0;
      l1       <= 1'b0;
      v2       <= 1'b0;
      l2       <= 1'b0;
      valid_op <= 1'b0;
      end_op   <= 1'b0;
      data_out <= '0;
    end else begin
      v0       <= accept_c && win_ok_c;
      l0       <= accept_c && last_c;
      v1       <= v0;
      l1       <= l0;
      v2       <= v1;
      l2       <= l1;
      valid_op <= v2;
      end_op   <= v2 && l2;
      if (v2) data_out <= out_c;
    end
  end

endmodule

// File: tb/tb_conv_layer_mc.sv
// Scoreboard bench for conv_layer_mc: three instances cover basic/ReLU/reset, stride/identity and 2-channel narrowing.
module tb_conv_layer_mc;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic        last;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  bit busy_chk [3];

  logic          a_rst, a_valid, a_vo, a_eo, a_busy;
  logic [15:0]   a_data, a_b, a_do;
  logic [143:0]  a_w;
  logic          b_rst, b_valid, b_vo, b_eo, b_busy;
  logic [15:0]   b_data, b_b, b_do;
  logic [143:0]  b_w;
  logic          c_rst, c_valid, c_vo, c_eo, c_busy;
  logic [31:0]   c_data;
  logic [15:0]   c_b, c_do;
  logic [287:0]  c_w;

  conv_layer_mc #(.DW(16), .FRAC(8), .W(6), .K(3), .S(1), .CH(1), .ACTYPE(1)) u_a (
    .clk(clk), .global_rst(a_rst), .in_valid(a_valid), .in_data(a_data), .weight(a_w),
    .bias(a_b), .data_out(a_do), .valid_op(a_vo), .end_op(a_eo), .busy(a_busy));

  conv_layer_mc #(.DW(16), .FRAC(8), .W(7), .K(3), .S(2), .CH(1), .ACTYPE(0)) u_b (
    .clk(clk), .global_rst(b_rst), .in_valid(b_valid), .in_data(b_data), .weight(b_w),
    .bias(b_b), .data_out(b_do), .valid_op(b_vo), .end_op(b_eo), .busy(b_busy));

  conv_layer_mc #(.DW(16), .FRAC(8), .W(4), .K(3), .S(1), .CH(2), .ACTYPE(1)) u_c (
    .clk(clk), .global_rst(c_rst), .in_valid(c_valid), .in_data(c_data), .weight(c_w),
    .bias(c_b), .data_out(c_do), .valid_op(c_vo), .end_op(c_eo), .busy(c_busy));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever an instance presents a result.
  task automatic mon(input int id, input logic vo, input logic [15:0] dout, input logic eo,
                     input logic bsy);
    exp_t e;
    if (busy_chk[id]) begin
      check($sformatf("dut%0d_busy_after_end", id), 32'(bsy), 32'd0);
      busy_chk[id] = 1'b0;
    end
    if (vo) begin
      if (sbq.size() == 0 || int'(sbq[0].id) != id) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_valid: got data %h expected no output", id, dout);
      end else begin
        e = sbq.pop_front();
        check($sformatf("dut%0d_data", id), 32'(dout), 32'(e.data));
        check($sformatf("dut%0d_end_op", id), 32'(eo), 32'(e.last));
        check($sformatf("dut%0d_latency_cycle", id), 32'(cyc), e.cyc);
      end
      if (eo) busy_chk[id] = 1'b1;
    end else if (eo) begin
      check($sformatf("dut%0d_end_without_valid", id), 32'(eo), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_vo, a_do, a_eo, a_busy);
    mon(1, b_vo, b_do, b_eo, b_busy);
    mon(2, c_vo, c_do, c_eo, c_busy);
  end

  task automatic set_px(input int id, input logic vld, input logic [15:0] v);
    case (id)
      0: begin a_valid = vld; a_data = v; end
      1: begin b_valid = vld; b_data = v; end
      2: begin c_valid = vld; c_data = {v, v}; end
      default: ;
    endcase
  endtask

  // Streams npix raster pixels; expected output is pushed when a window completes.
  task automatic drive_frame(input int id, input int w, input int s, input int npix,
                             input bit gap, input bit perturb, input bit ramp,
                             input logic [15:0] pix, input logic [15:0] exp_v);
    int r, c, lastp;
    logic [15:0] v, ev;
    exp_t e;
    lastp = 2 + ((w - 3) / s) * s;
    for (int i = 0; i < npix; i++) begin
      r  = i / w;
      c  = i % w;
      v  = ramp ? 16'((r * w + c) << 8) : pix;
      ev = ramp ? 16'(((r - 1) * w + (c - 1)) << 8) : exp_v;
      @(negedge clk);
      set_px(id, 1'b1, v);
      if (i == 1 && id == 0) begin
        check("dut0_busy_in_frame", 32'(a_busy), 32'd1);
        if (perturb) begin
          a_w = '0;
          a_b = 16'h1234;
        end
      end
      if (r >= 2 && c >= 2 && ((r - 2) % s) == 0 && ((c - 2) % s) == 0) begin
        e.id   = 2'(id);
        e.data = ev;
        e.last = (r == lastp) && (c == lastp);
        e.cyc  = 32'(cyc + 4);
        sbq.push_back(e);
      end
      if (gap) begin
        @(negedge clk);
        set_px(id, 1'b0, v);
      end
    end
    @(negedge clk);
    set_px(id, 1'b0, 16'h0000);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({name, "_outputs_drained"}, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic reset_a_midframe();
    int k;
    @(negedge clk);
    a_rst   = 1'b1;
    a_valid = 1'b1;
    a_data  = 16'h7777;
    k = cyc + 1;
    while (sbq.size() > 0 && sbq[$].cyc >= 32'(k)) void'(sbq.pop_back());
    repeat (3) begin
      @(negedge clk);
      check("dut0_busy_in_reset", 32'(a_busy), 32'd0);
      check("dut0_valid_in_reset", 32'(a_vo), 32'd0);
    end
    a_rst   = 1'b0;
    a_valid = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    a_w = {9{16'h0100}}; b_w = '0; c_w = {18{16'h0100}};
    a_b = '0; b_b = '0; c_b = '0;
    repeat (3) @(negedge clk);
    check("dut0_reset_data_out", 32'(a_do), 32'd0);
    check("dut0_reset_valid_op", 32'(a_vo), 32'd0);
    check("dut0_reset_end_op", 32'(a_eo), 32'd0);
    check("dut0_reset_busy", 32'(a_busy), 32'd0);
    check("dut1_reset_busy", 32'(b_busy), 32'd0);
    check("dut2_reset_data_out", 32'(c_do), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    @(negedge clk);

    // Basic 6x6 frame: 9 taps of 1.0*1.0 -> 9.0
    drive_frame(0, 6, 1, 36, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0900);
    drain("basic");

    // Bias 1.0 on top of the basic frame -> 10.0
    a_b = 16'h0100;
    drive_frame(0, 6, 1, 36, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0A00);
    drain("bias");

    // Negative weights under ReLU clamp to zero
    a_w = {9{16'hFF00}};
    a_b = '0;
    drive_frame(0, 6, 1, 36, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000);
    drain("relu");

    // Gapped input with weights/bias disturbed after pixel (0,0): results unchanged
    a_w = {9{16'h0100}};
    a_b = '0;
    drive_frame(0, 6, 1, 36, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0900);
    drain("gapped");

    // Reset after 20 pixels, then a clean frame
    a_w = {9{16'h0100}};
    a_b = '0;
    drive_frame(0, 6, 1, 20, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0900);
    reset_a_midframe();
    drive_frame(0, 6, 1, 36, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0900);
    drain("after_reset");

    // Stride 2 on a 7x7 ramp with a centre-only kernel
    b_w = '0;
    b_w[4*16 +: 16] = 16'h0100;
    drive_frame(1, 7, 2, 49, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    drain("stride");

    // Identity activation: 9 * (-1.0) -> -9.0
    b_w = {9{16'hFF00}};
    drive_frame(1, 7, 2, 49, 1'b0, 1'b0, 1'b0, 16'h0100, 16'hF700);
    drain("identity");

    // Two channels of 127.0: 18*127 overflows 16 bits
`ifdef CONV_SAT_EN
    drive_frame(2, 4, 1, 16, 1'b0, 1'b0, 1'b0, 16'h7F00, 16'h7FFF);
`else
    drive_frame(2, 4, 1, 16, 1'b0, 1'b0, 1'b0, 16'h7F00, 16'hEE00);
`endif
    drain("narrowing");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_mc.md
Name: conv_layer_mc

Overview:
Streaming multi-channel 2D convolution layer. It is the parametrised successor of the single-channel `layer` block: configurable channel count, stride, fixed-point format and activation. It takes one raster-ordered pixel per accepted beat, with all CH input channels in parallel. It convolves each channel with its own KxK kernel, sums across channels, adds bias, then applies the activation. It emits one output-feature-map pixel per valid window and sits between the input DMA/previous layer and the pooling stage.

Parameters:
- DW, 16, signed data width (weights, bias, pixels, output).
- FRAC, 8, fractional bits of the Q format.
- W, 28, input image width and height (square).
- K, 3, kernel size, K >= 2, K <= W.
- S, 1, stride, 1..K.
- CH, 1, input channel count.
- ACTYPE, 1, 0 = identity, 1 = ReLU.

Ports:
- clk  in  1  clock.
- global_rst  in  1  synchronous active-high reset.
- in_valid  in  1  pixel beat present; acts as the clock enable for the counters and line buffers.
- in_data  in  CH*DW  channel c occupies bits [c*DW +: DW].
- weight  in  CH*K*K*DW  tap (c, r, q) occupies bits [((c*K*K)+r*K+q)*DW +: DW]; r is row, q is column, (0,0) is the top-left tap.
- bias  in  DW  Q-format bias.
- data_out  out  DW  result pixel.
- valid_op  out  1  data_out valid this cycle.
- end_op  out  1  pulses together with the last output of a frame.
- busy  out  1  frame in progress: first pixel accepted, last output not yet emitted.

Behaviour:
- Reset values:
  - data_out = 0, valid_op = 0, end_op = 0, busy = 0.
  - Row/column counters = 0.
  - Pipeline valid bits = 0.
  - Line-buffer RAM contents are not cleared; they are don't-care.
- Acceptance and counters:
  - A pixel is accepted on any rising edge with in_valid = 1 and global_rst = 0. There is no backpressure.
  - col increments per accepted pixel and wraps at W-1. row increments on col wrap.
  - After pixel (W-1, W-1), both counters return to 0; the next accepted pixel starts a new frame.
- Parameter latch: weight and bias are latched on acceptance of pixel (0,0). Changes mid-frame have no effect.
- Windowing:
  - Per channel there are K-1 line buffers of depth W plus a KxK shift-register window.
  - The accepted pixel at (row, col) completes a window when all of the following hold:
    - row >= K-1 and col >= K-1;
    - (row-K+1) mod S = 0;
    - (col-K+1) mod S = 0.
  - Output dimension OW = (W-K)/S + 1, integer division. OW*OW outputs are produced per frame.
  - Trailing rows/columns that do not fit a full stride step produce nothing.
- Pipeline: fixed latency of 3 cycles. If the completing pixel is accepted at edge N, valid_op is high for exactly one cycle after edge N+3.
  - Stage 1 registers CH*K*K products.
  - Stage 2 registers the sum.
  - Stage 3 registers activation/format.
  - Pipeline stages advance every cycle regardless of in_valid, so gaps in in_valid do not stall in-flight results.
- Arithmetic:
  - Products are 2*DW signed.
  - The accumulator is 2*DW + clog2(CH*K*K) + 1 bits, which cannot overflow.
  - sum = sum(products) + (bias <<< FRAC).
  - Result = sum >>> FRAC, an arithmetic shift truncating toward minus infinity.
  - ReLU (ACTYPE=1) clamps negative results to 0.
  - Final DW narrowing is defined under Optional Feature.
- End and busy:
  - end_op = valid_op for output index OW*OW-1.
  - busy rises on acceptance of (0,0) and falls the cycle after end_op.
- Reset mid-frame:
  - Counters and pipeline valid bits are cleared; no pending valid_op is emitted.
  - The next accepted pixel is (0,0) of a fresh frame and produces exactly OW*OW outputs.
- Simultaneous events: global_rst has priority over in_valid in the same cycle, and that pixel is dropped.

Optional Feature:
- CONV_SAT_EN defined: the final narrowing saturates to [-2^(DW-1), 2^(DW-1)-1], i.e. 0x8000..0x7FFF for DW=16.
- CONV_SAT_EN undefined: data_out is the low DW bits of the result (two's-complement wrap).
- Latency is identical in both builds.

Decomposition:
- Package conv_pkg holds:
  - ACT_IDENTITY = 0, ACT_RELU = 1;
  - clog2 function;
  - helper functions for OW and accumulator width.
- Sub-module conv_line_buffer: one channel's K-1 row buffers (depth W, width DW) plus the KxK window registers, with shift enable = in_valid. It is instantiated CH times by generate.

Test Plan:
- Basic frame (W=6, K=3, S=1, CH=1, FRAC=8): all inputs 0x0100, all weights 0x0100, bias 0 -> 16 outputs, each 0x0900. end_op is set on the 16th. First valid_op comes 3 cycles after pixel (2,2) is accepted.
- Stride (W=7, K=3, S=2): ramp input (value = row*7+col, Q8.8) with the centre-tap-only kernel 0x0100 -> 9 outputs equal to input at (1,1), (1,3), (1,5), (3,1), ... (5,5).
- Activation: all weights 0xFF00 (-1.0), inputs 0x0100, bias 0 -> 0x0000 with ACTYPE=1; 0xF700 with ACTYPE=0.
- Saturation: inputs 0x7F00, weights 0x0100, CH=2 -> 0x7FFF when CONV_SAT_EN is defined; low 16 bits of 18*127 (0xEE00) when undefined.
- Gapped input: the basic frame with in_valid toggling every cycle -> identical 16 values. Each appears 3 cycles after its completing pixel.
- Reset mid-frame: assert global_rst after 20 pixels, then send a full basic frame -> exactly 16 outputs. No stale valid_op. busy=0 during reset.
